// File: rtl/mux_tree_pipelined_if.sv
// Request/response bundle for the pipelined N:1 word selector.
// master drives requests and pipeline advance; slave returns the selected word.
interface mux_tree_pipelined_if #(
  parameter int unsigned N_IN  = 64,
  parameter int unsigned WIDTH = 1
);
  localparam int unsigned SEL_W = $clog2(N_IN);

  logic                    en;
  logic                    in_valid;
  logic [SEL_W-1:0]        sel;
  logic [N_IN*WIDTH-1:0]   din;
  logic                    out_valid;
  logic [WIDTH-1:0]        dout;

  modport master (
    output en,
    output in_valid,
    output sel,
    output din,
    input  out_valid,
    input  dout
  );

  modport slave (
    input  en,
    input  in_valid,
    input  sel,
    input  din,
    output out_valid,
    output dout
  );
endinterface

// File: rtl/mux_tree_pipelined.sv
// N:1 WIDTH-bit selector built as a binary tree of 2:1 levels, registered every
// LVL_PER_STG levels. Latency is ceil(SEL_W / LVL_PER_STG) enabled cycles.
module mux_tree_pipelined #(
  parameter int unsigned N_IN        = 64,
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned LVL_PER_STG = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  mux_tree_pipelined_if.slave   bus
);
  localparam int unsigned SEL_W  = $clog2(N_IN);
  localparam int unsigned STAGES = (SEL_W + LVL_PER_STG - 1) / LVL_PER_STG;
  localparam int unsigned LEAVES = 1 << SEL_W;

  // Leaves beyond N_IN read as zero, so out-of-range selects return 0.
  logic [LEAVES*WIDTH-1:0] din_pad;
  always_comb begin
    din_pad = '0;
    din_pad[N_IN*WIDTH-1:0] = bus.din;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int unsigned LO = s * LVL_PER_STG;
    localparam int unsigned HI = (LO + LVL_PER_STG < SEL_W) ? LO + LVL_PER_STG : SEL_W;
    localparam int unsigned NI = LEAVES >> LO;
    localparam int unsigned NO = LEAVES >> HI;

    logic [NI*WIDTH-1:0] cand_in;
    logic [NI*WIDTH-1:0] cand_tmp;
    logic [SEL_W-1:0]    sel_in;
    logic                valid_in;
    logic [NO*WIDTH-1:0] data_d, data_q;
    logic [SEL_W-1:0]    sel_d, sel_q;
    logic                valid_d, valid_q;

    if (s == 0) begin : g_src
      assign cand_in  = din_pad;
      assign sel_in   = bus.sel;
      assign valid_in = bus.in_valid;
    end else begin : g_src
      assign cand_in  = g_stg[s-1].data_q;
      assign sel_in   = g_stg[s-1].sel_q;
      assign valid_in = g_stg[s-1].valid_q;
    end

    // In-place reduction: slot j is written only after slots 2j and 2j+1 are read.
    always_comb begin
      cand_tmp = cand_in;
      for (int unsigned lvl = LO; lvl < HI; lvl++) begin
        for (int unsigned j = 0; j < (LEAVES >> (lvl + 1)); j++) begin
          cand_tmp[j*WIDTH +: WIDTH] = sel_in[lvl] ? cand_tmp[(2*j+1)*WIDTH +: WIDTH]
                                                   : cand_tmp[(2*j)*WIDTH +: WIDTH];
        end
      end
      data_d = cand_tmp[NO*WIDTH-1:0];
      sel_d  = '0;
      for (int unsigned i = HI; i < SEL_W; i++) begin
        sel_d[i] = sel_in[i];
      end
      valid_d = valid_in;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q  <= '0;
        sel_q   <= '0;
        valid_q <= 1'b0;
      end else if (bus.en) begin
        data_q  <= data_d;
        sel_q   <= sel_d;
        valid_q <= valid_d;
      end
    end
  end

  assign bus.dout      = g_stg[STAGES-1].data_q;
  assign bus.out_valid = g_stg[STAGES-1].valid_q;
endmodule

// File: tb/tb_mux_tree_pipelined.sv
// Drives several selector configurations with shared stimulus and checks each against
// a delay-line scoreboard of word[sel] results plus isolated-pulse latency measurements.
module tb_mux_tree_pipelined;
  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic [5:0]  sel_raw;
  logic [63:0] din_raw;
  bit          armed;
  bit          measure;
  int          checks;
  int          failures;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : lane
    localparam int unsigned N  = (g == 4) ? 5 : 64;
    localparam int unsigned W  = (g == 4) ? 8 : 1;
    localparam int unsigned L  = (g == 1) ? 6 : (g == 2) ? 1 : (g == 3) ? 4 : 2;
    localparam int unsigned SW = $clog2(N);
    localparam int unsigned S  = (SW + L - 1) / L;

    mux_tree_pipelined_if #(.N_IN(N), .WIDTH(W)) bus ();

    assign bus.en       = en;
    assign bus.in_valid = in_valid;
    assign bus.sel      = sel_raw[SW-1:0];
    assign bus.din      = din_raw[N*W-1:0];

    mux_tree_pipelined #(
      .N_IN        (N),
      .WIDTH       (W),
      .LVL_PER_STG (L)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    bit           qv[$];
    logic [W-1:0] qd[$];
    bit           qc[$];
    bit           cur_v, cur_c;
    logic [W-1:0] cur_d;
    int unsigned  sidx;
    logic [W-1:0] e_d;
    int           lat;

    // Reference: a request entering on an enabled edge leaves S enabled edges later.
    always @(posedge clk) begin
      if (reset) begin
        qv.delete(); qd.delete(); qc.delete();
        for (int i = 0; i < int'(S) - 1; i++) begin
          qv.push_back(1'b0); qd.push_back('0); qc.push_back(1'b1);
        end
        cur_v = 1'b0; cur_d = '0; cur_c = 1'b1;
        lat = 0;
      end else if (en) begin
        sidx = int'(sel_raw[SW-1:0]);
        e_d  = (sidx < N) ? din_raw[sidx*W +: W] : '0;
        qv.push_back(in_valid); qd.push_back(e_d); qc.push_back(in_valid);
        cur_v = qv.pop_front(); cur_d = qd.pop_front(); cur_c = qc.pop_front();
        if (measure) begin
          if (in_valid) lat = 1;
          else if (lat > 0) lat++;
        end
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        checks++;
        if (bus.out_valid !== cur_v) begin
          failures++;
          $display("FAIL lane%0d out_valid got=%b exp=%b t=%0t", g, bus.out_valid, cur_v, $time);
        end
        if (cur_c) begin
          checks++;
          if (bus.dout !== cur_d) begin
            failures++;
            $display("FAIL lane%0d dout got=%h exp=%h t=%0t", g, bus.dout, cur_d, $time);
          end
        end
        if (lat > 0 && bus.out_valid) begin
          checks++;
          if (lat != int'(S)) begin
            failures++;
            $display("FAIL lane%0d latency got=%0d exp=%0d", g, lat, S);
          end
          lat = 0;
        end else if (lat > 12) begin
          checks++;
          failures++;
          $display("FAIL lane%0d latency timeout got=%0d exp=%0d", g, lat, S);
          lat = 0;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [5:0] s, input logic e);
    @(negedge clk);
    in_valid = v;
    sel_raw  = s;
    en       = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 6'd0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; sel_raw = '0; din_raw = '0;
    armed = 1'b0; measure = 1'b0; checks = 0; failures = 0;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    reset = 1'b0;

    // Back-to-back sweep of a fixed pattern.
    din_raw = 64'd69420;
    for (int i = 0; i < 64; i++) drive(1'b1, 6'(i), 1'b1);
    idle(8);

    // Sweep with a five-cycle stall in the middle.
    din_raw = 64'd23485;
    for (int i = 0; i < 64; i++) begin
      if (i == 30) for (int k = 0; k < 5; k++) drive(1'b1, 6'(i), 1'b0);
      drive(1'b1, 6'(i), 1'b1);
    end
    idle(8);

    // Request immediately followed by a one-cycle reset.
    drive(1'b1, 6'd5, 1'b1);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(8);

    // Short words; selects 5..7 fall outside the 5-word lane.
    din_raw = 64'h0000_00A4_A3A2_A1A0;
    drive(1'b1, 6'd4, 1'b1);
    drive(1'b1, 6'd7, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, 6'(i), 1'b1);
    idle(8);

    // Isolated pulses for latency measurement.
    for (int r = 0; r < 3; r++) begin
      idle(10);
      measure = 1'b1;
      din_raw = {$urandom, $urandom};
      drive(1'b1, 6'($urandom_range(0, 63)), 1'b1);
      idle(10);
      measure = 1'b0;
    end

    // Alternating valid with random data, then random stalls as well.
    for (int i = 0; i < 400; i++) begin
      din_raw = {$urandom, $urandom};
      drive(1'(i % 2), 6'($urandom_range(0, 63)),
            (i < 150) ? 1'b1 : 1'($urandom_range(0, 3) != 0));
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
